// File: rtl/dmem_mmio.sv
// Data-side responder: word RAM plus MMIO page (TX byte FIFO, timer/compare irq); reads are combinational, writes land at posedge.
// The TX stream is valid/ready with the head byte held while stalled; pushes into a full FIFO without a same-cycle pop are dropped and flagged.
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [27:0] MMIO_PAGE = 28'hFFFF000;

    // ---------------- address decode ----------------
    logic              ram_sel;
    logic              page_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              txdata_wr;
    logic              status_wr;
    logic              timer_wr;
    logic              compare_wr;
    logic              unused_addr;

    assign ram_sel     = (ALUResult[31:RAM_AW+2] == '0);
    assign page_sel    = (ALUResult[31:4] == MMIO_PAGE);
    assign ram_idx     = ALUResult[RAM_AW+1:2];
    assign txdata_wr   = MemWrite && page_sel && (ALUResult[3:2] == 2'd0);
    assign status_wr   = MemWrite && page_sel && (ALUResult[3:2] == 2'd1);
    assign timer_wr    = MemWrite && page_sel && (ALUResult[3:2] == 2'd2);
    assign compare_wr  = MemWrite && page_sel && (ALUResult[3:2] == 2'd3);
    assign unused_addr = ^ALUResult[1:0];

    // ---------------- RAM (no reset) ----------------
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (MemWrite && ram_sel) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = !empty && tx_ready;
    // A pop in the same cycle frees the slot the push needs, so full is not a drop then.
    assign push_ok = txdata_wr && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = (txdata_wr && !push_ok) || (ovf_q && !(status_wr && WriteData[2]));
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    // ---------------- timer / compare ----------------
    logic [31:0] timer_q, timer_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;

    always_comb begin
        timer_d   = timer_wr ? WriteData : timer_q + 32'd1;
        compare_d = compare_wr ? WriteData : compare_q;
        // Setting the match flag takes priority over a simultaneous W1C clear.
        match_d   = (timer_q == compare_q) || (match_q && !(status_wr && WriteData[3]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    assign irq = match_q;

    // ---------------- read mux ----------------
    logic [31:0] status_word;

    assign status_word = {16'h0000, 8'(count_q), 4'h0, match_q, ovf_q, full, empty};

    always_comb begin
        ReadData = 32'h0000_0000;
        if (ram_sel) begin
            ReadData = ram_q[ram_idx];
        end else if (page_sel) begin
            case (ALUResult[3:2])
                2'd1:    ReadData = status_word;
                2'd2:    ReadData = timer_q;
                2'd3:    ReadData = compare_q;
                default: ReadData = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus random traffic against a queue/array reference model.
module tb_dmem_mmio;

    localparam logic [31:0] TXD = 32'hFFFF_0000;
    localparam logic [31:0] STS = 32'hFFFF_0004;
    localparam logic [31:0] TMR = 32'hFFFF_0008;
    localparam logic [31:0] CMP = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    // Reference model
    int unsigned  tim_m;
    int unsigned  cmp_m;
    bit           match_m;
    bit           ovf_m;
    byte unsigned q_m[$];
    logic [31:0]  ram_m [64];
    bit           ram_v [64];

    task automatic model_reset();
        q_m.delete();
        ovf_m   = 1'b0;
        match_m = 1'b0;
        tim_m   = 0;
        cmp_m   = 32'hFFFF_FFFF;
    endtask

    function automatic logic [31:0] status_m();
        return {16'h0000, 8'(q_m.size()), 4'h0, match_m, ovf_m, q_m.size() == 8, q_m.size() == 0};
    endfunction

    function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        v = 32'h0;
        if (w < 32'd256) begin
            if (!ram_v[w[7:2]]) return 1'b0;
            v = ram_m[w[7:2]];
            return 1'b1;
        end
        case (w)
            STS:     v = status_m();
            TMR:     v = tim_m;
            CMP:     v = cmp_m;
            default: v = 32'h0;
        endcase
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check combinational outputs mid-cycle, advance model at the edge.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        logic [31:0] e;
        logic [31:0] w;
        bit          known;
        int          sz;
        bit          pop;
        bit          push;
        bit          acc;
        MemWrite  = we;
        ALUResult = a;
        WriteData = wd;
        tx_ready  = rdy;
        @(negedge clk);
        check("tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
        check("tx_data", 32'(tx_data), (q_m.size() != 0) ? 32'(q_m[0]) : 32'h0);
        check("irq", 32'(irq), 32'(match_m));
        known = exp_read(a, e);
        if (known) check("rdata", ReadData, e);
        @(posedge clk);
        w    = a & 32'hFFFF_FFFC;
        sz   = q_m.size();
        pop  = (sz != 0) && rdy;
        push = we && (w == TXD);
        acc  = (sz < 8) || pop;
        if (pop) void'(q_m.pop_front());
        if (push && acc) q_m.push_back(wd[7:0]);
        if (push && !acc) ovf_m = 1'b1;
        else if (we && w == STS && wd[2]) ovf_m = 1'b0;
        if (tim_m == cmp_m) match_m = 1'b1;
        else if (we && w == STS && wd[3]) match_m = 1'b0;
        tim_m = (we && w == TMR) ? wd : tim_m + 1;
        if (we && w == CMP) cmp_m = wd;
        if (we && w < 32'd256) begin
            ram_m[w[7:2]] = wd;
            ram_v[w[7:2]] = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        bit          we;
        bit          rdy;
        int          op;

        reset     = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        tx_ready  = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        ALUResult = STS; #1 check("rst_status", ReadData, 32'h0000_0001);
        ALUResult = TMR; #1 check("rst_timer", ReadData, 32'h0);
        ALUResult = CMP; #1 check("rst_compare", ReadData, 32'hFFFF_FFFF);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // RAM write/read and aliasing
        step(1'b1, 32'h14, 32'h1234_5678, 1'b0);
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 32'h10, 32'h0, 1'b0);
        check("ram_10", ReadData, 32'hDEAD_BEEF);
        step(1'b0, 32'h14, 32'h0, 1'b0);
        check("ram_14", ReadData, 32'h1234_5678);
        step(1'b0, 32'h13, 32'h0, 1'b0);
        check("ram_13_alias", ReadData, 32'hDEAD_BEEF);

        // FIFO ordering
        step(1'b1, TXD, 32'h41, 1'b0);
        step(1'b1, TXD, 32'h42, 1'b0);
        step(1'b1, TXD, 32'h43, 1'b0);
        step(1'b0, STS, 32'h0, 1'b0);
        check("fifo_count3", 32'(ReadData[15:8]), 32'd3);
        check("fifo_head41", 32'(tx_data), 32'h41);
        step(1'b0, STS, 32'h0, 1'b1);
        check("fifo_head42", 32'(tx_data), 32'h42);
        step(1'b0, STS, 32'h0, 1'b1);
        check("fifo_head43", 32'(tx_data), 32'h43);
        step(1'b0, STS, 32'h0, 1'b1);
        check("fifo_drained_valid", 32'(tx_valid), 32'h0);
        check("fifo_drained_status", ReadData, 32'h0000_0001);

        // Overflow
        for (int i = 0; i < 9; i++) step(1'b1, TXD, 32'h50 + i, 1'b0);
        step(1'b0, STS, 32'h0, 1'b0);
        check("ovf_status", ReadData, 32'h0000_0806);
        step(1'b1, STS, 32'h4, 1'b0);
        check("ovf_cleared", ReadData, 32'h0000_0802);
        step(1'b1, TXD, 32'h60, 1'b1);
        step(1'b0, STS, 32'h0, 1'b0);
        check("full_push_pop", ReadData, 32'h0000_0802);
        for (int i = 0; i < 9; i++) step(1'b0, STS, 32'h0, 1'b1);
        check("ovf_drained", ReadData, 32'h0000_0001);

        // Timer compare / irq
        step(1'b1, CMP, 32'd20, 1'b0);
        step(1'b1, TMR, 32'd10, 1'b0);
        repeat (10) step(1'b0, TMR, 32'h0, 1'b0);
        check("irq_not_yet", 32'(irq), 32'h0);
        step(1'b0, TMR, 32'h0, 1'b0);
        check("irq_rise", 32'(irq), 32'h1);
        check("timer_after_match", ReadData, 32'd21);
        step(1'b1, STS, 32'h8, 1'b0);
        check("irq_cleared", 32'(irq), 32'h0);

        // Timer wrap
        step(1'b1, TMR, 32'hFFFF_FFFE, 1'b0);
        check("wrap_load", ReadData, 32'hFFFF_FFFE);
        step(1'b0, TMR, 32'h0, 1'b0);
        check("wrap_ffffffff", ReadData, 32'hFFFF_FFFF);
        step(1'b0, TMR, 32'h0, 1'b0);
        check("wrap_zero", ReadData, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            op  = int'($urandom_range(0, 7));
            rdy = 1'($urandom_range(0, 1));
            we  = 1'b0;
            wd  = $urandom;
            a   = STS;
            case (op)
                0: begin we = 1'b1; a = ($urandom_range(8, 63) << 2) | $urandom_range(0, 3); end
                1: a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                2: begin we = 1'b1; a = TXD | $urandom_range(0, 3); end
                3: begin we = 1'($urandom_range(0, 1)); a = STS; wd = $urandom_range(0, 15); end
                4: begin we = 1'($urandom_range(0, 1)); a = TMR; wd = cmp_m - $urandom_range(0, 5); end
                5: begin we = 1'b1; a = CMP; wd = tim_m + $urandom_range(1, 6); end
                6: begin
                    we = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 3))
                        0: a = 32'h0000_0100;
                        1: a = 32'hFFFF_0010;
                        2: a = 32'h8000_0000;
                        default: a = 32'hFFFE_0000;
                    endcase
                end
                default: a = STS;
            endcase
            step(we, a, wd, rdy);
        end

        // Async reset mid-drain
        repeat (12) step(1'b0, STS, 32'h0, 1'b1);
        step(1'b1, CMP, 32'd100, 1'b0);
        step(1'b1, TMR, 32'd100, 1'b0);
        step(1'b0, STS, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, TXD, 32'h70 + i, 1'b0);
        step(1'b0, STS, 32'h0, 1'b1);
        check("pre_rst_count", 32'(ReadData[15:8]), 32'd4);
        check("pre_rst_irq", 32'(irq), 32'h1);
        check("pre_rst_valid", 32'(tx_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(tx_valid), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        check("async_rst_data", 32'(tx_data), 32'h0);
        check("async_rst_status", ReadData, 32'h0000_0001);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        step(1'b0, STS, 32'h0, 1'b0);
        check("post_rst_status", ReadData, 32'h0000_0001);
        step(1'b0, 32'h10, 32'h0, 1'b0);
        check("post_rst_ram", ReadData, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
